// File: rtl/mem_dma.sv
// mem_dma: block-transfer engine that drives the address, write-enable and
// write-data ports of a single-port data memory (async read, negedge write).
// Copies a run of words within the memory, or fills a run with a constant.
// Optional feature macro: MEM_DMA_CHECKSUM_EN adds o_checksum, the running sum
// of every word written during the current transfer.
module mem_dma #(
  parameter int p_WORD_LEN = 16,
  parameter int p_ADDR_LEN = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [p_ADDR_LEN-1:0] i_src,
  input  logic [p_ADDR_LEN-1:0] i_dst,
  input  logic [p_ADDR_LEN:0]   i_len,
  input  logic [p_WORD_LEN-1:0] i_fill_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
`ifdef MEM_DMA_CHECKSUM_EN
  output logic [p_WORD_LEN-1:0] o_checksum,
`endif
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FILL} state_t;

  localparam logic [p_ADDR_LEN:0] c_ONE = {{p_ADDR_LEN{1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [p_ADDR_LEN-1:0] src_q, src_d;
  logic [p_ADDR_LEN-1:0] dst_q, dst_d;
  logic [p_ADDR_LEN:0]   len_q, len_d;
  logic [p_ADDR_LEN:0]   k_q, k_d;
  logic [p_WORD_LEN-1:0] fill_q, fill_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_en_q, wr_en_d;
  logic [p_ADDR_LEN-1:0] addr_q, addr_d;
  logic [p_WORD_LEN-1:0] wr_data_q, wr_data_d;

  logic                  accept;
  logic                  last_word;
  logic [p_ADDR_LEN:0]   k_inc;

  assign accept    = (state_q == S_IDLE) && i_start;
  assign k_inc     = k_q + c_ONE;
  assign last_word = (k_inc == len_q);

  // State, latched transfer parameters and registered outputs.
  // The write-data register doubles as the hold register for the word read
  // in RD, since it captures i_mem_rd_data on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      k_q       <= '0;
      fill_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      k_q       <= k_d;
      fill_q    <= fill_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wr_en_q   <= wr_en_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next state, parameter latching on acceptance, and word index advance.
  // The index only advances when a write cycle completes.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    k_d     = k_q;
    fill_d  = fill_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          src_d  = i_src;
          dst_d  = i_dst;
          len_d  = i_len;
          fill_d = i_fill_data;
          k_d    = '0;
          if (i_len == '0) state_d = S_IDLE;
          else if (i_mode) state_d = S_FILL;
          else             state_d = S_RD;
        end
      end
      S_RD: state_d = S_WR;
      S_WR: begin
        k_d     = k_inc;
        state_d = last_word ? S_IDLE : S_RD;
      end
      S_FILL: begin
        k_d     = k_inc;
        state_d = last_word ? S_IDLE : S_FILL;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the upcoming state and index so the
  // memory sees a stable address/data for the whole cycle it is in.
  always_comb begin
    busy_d    = (state_d != S_IDLE);
    wr_en_d   = (state_d == S_WR) || (state_d == S_FILL);
    done_d    = (accept && (i_len == '0)) ||
                (((state_q == S_WR) || (state_q == S_FILL)) && last_word);
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    case (state_d)
      S_RD:   addr_d = src_d + k_d[p_ADDR_LEN-1:0];
      S_WR: begin
        addr_d    = dst_d + k_d[p_ADDR_LEN-1:0];
        wr_data_d = i_mem_rd_data;
      end
      S_FILL: begin
        addr_d    = dst_d + k_d[p_ADDR_LEN-1:0];
        wr_data_d = fill_d;
      end
      default: ;
    endcase
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_mem_wr_en   = wr_en_q;
  assign o_mem_addr    = addr_q;
  assign o_mem_wr_data = wr_data_q;

`ifdef MEM_DMA_CHECKSUM_EN
  logic [p_WORD_LEN-1:0] sum_q, sum_d;

  // Running sum of written words; restarts with every accepted transfer.
  always_comb begin
    sum_d = sum_q;
    if (accept)       sum_d = '0;
    else if (wr_en_q) sum_d = sum_q + wr_data_q;
  end

  // Checksum register.
  always_ff @(posedge i_clk) begin
    if (i_rst) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign o_checksum = sum_q;
`endif

endmodule

// File: tb/tb_mem_dma.sv
// tb_mem_dma: directed self-checking bench for mem_dma with a behavioural
// memory (async read, negedge write). Checksum checks compile in when
// MEM_DMA_CHECKSUM_EN is defined.
module tb_mem_dma;
  localparam int W = 16;
  localparam int A = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode;
  logic [A-1:0] src;
  logic [A-1:0] dst;
  logic [A:0]   len;
  logic [W-1:0] fill_data;
  logic         busy;
  logic         done;
  logic [A-1:0] mem_addr;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic [W-1:0] rd_data;
`ifdef MEM_DMA_CHECKSUM_EN
  logic [W-1:0] checksum;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int wr_count = 0;

  logic [W-1:0] mem [0:(1<<A)-1];

  mem_dma #(.p_WORD_LEN(W), .p_ADDR_LEN(A)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_mode(mode),
    .i_src(src),
    .i_dst(dst),
    .i_len(len),
    .i_fill_data(fill_data),
    .o_busy(busy),
    .o_done(done),
    .o_mem_addr(mem_addr),
    .o_mem_wr_en(wr_en),
    .o_mem_wr_data(wr_data),
`ifdef MEM_DMA_CHECKSUM_EN
    .o_checksum(checksum),
`endif
    .i_mem_rd_data(rd_data)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Behavioural memory: combinational read, write at negedge.
  assign rd_data = mem[mem_addr];
  always @(negedge clk) begin
    if (wr_en) begin
      mem[mem_addr] = wr_data;
      wr_count = wr_count + 1;
    end
  end

  // Step to #1 after the next posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns in cycle T0+1.
  task automatic start_xfer(input logic m, input logic [A-1:0] s, input logic [A-1:0] d,
                            input logic [A:0] n, input logic [W-1:0] f);
    mode = m; src = s; dst = d; len = n; fill_data = f;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Count cycles (current cycle = 1) until o_done, with a budget.
  task automatic wait_done(input int budget, output int cycles, output int busy_cycles,
                           output int wr_cycles, output bit timed_out);
    cycles = 1; busy_cycles = 0; wr_cycles = 0; timed_out = 1'b0;
    while (1) begin
      if (busy) busy_cycles++;
      if (wr_en) wr_cycles++;
      if (done) break;
      if (cycles >= budget) begin
        timed_out = 1'b1;
        break;
      end
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
    n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_wr_en got=%b want=0", wr_en); end
    n_cmp++; if (mem_addr !== 10'h000) begin n_bad++; $display("[TB] FAIL reset_addr got=%h want=000", mem_addr); end
    n_cmp++; if (wr_data !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_wr_data got=%h want=0000", wr_data); end
`ifdef MEM_DMA_CHECKSUM_EN
    n_cmp++; if (checksum !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_checksum got=%h want=0000", checksum); end
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_copy();
    logic [W-1:0] exp_w [4];
    int cyc, bcyc, wcyc;
    bit to;
    exp_w = '{16'h00A1, 16'h00B2, 16'h00C3, 16'h00D4};
    for (int i = 0; i < 4; i++) begin
      mem[10'h010 + i] = exp_w[i];
      mem[10'h200 + i] = 16'h0000;
    end
    start_xfer(1'b0, 10'h010, 10'h200, 11'd4, 16'h0000);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("[TB] FAIL copy_busy_t1 got=%b want=1", busy); end
    n_cmp++; if (mem_addr !== 10'h010) begin n_bad++; $display("[TB] FAIL copy_first_addr got=%h want=010", mem_addr); end
    wait_done(30, cyc, bcyc, wcyc, to);
    n_cmp++; if (to || cyc != 9) begin n_bad++; $display("[TB] FAIL copy_done_cycle got=%0d want=9 timeout=%0d", cyc, to); end
    n_cmp++; if (bcyc != 8) begin n_bad++; $display("[TB] FAIL copy_busy_cycles got=%0d want=8", bcyc); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL copy_busy_at_done got=%b want=0", busy); end
`ifdef MEM_DMA_CHECKSUM_EN
    n_cmp++; if (checksum !== 16'h02EA) begin n_bad++; $display("[TB] FAIL copy_checksum got=%h want=02ea", checksum); end
`endif
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[10'h200 + i] !== exp_w[i]) begin
        n_bad++; $display("[TB] FAIL copy_word%0d got=%h want=%h", i, mem[10'h200 + i], exp_w[i]);
      end
    end
    step();
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL copy_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_fill_wrap();
    int cyc, bcyc, wcyc;
    bit to;
    logic [A-1:0] a;
    for (int i = 0; i < 6; i++) begin
      a = 10'h3FD + i[A-1:0];
      mem[a] = 16'h1111;
    end
    start_xfer(1'b1, 10'h000, 10'h3FE, 11'd4, 16'h5A5A);
    wait_done(20, cyc, bcyc, wcyc, to);
    n_cmp++; if (to || cyc != 5) begin n_bad++; $display("[TB] FAIL fill_done_cycle got=%0d want=5 timeout=%0d", cyc, to); end
    n_cmp++; if (wcyc != 4) begin n_bad++; $display("[TB] FAIL fill_wr_cycles got=%0d want=4", wcyc); end
    n_cmp++; if (mem[10'h3FE] !== 16'h5A5A) begin n_bad++; $display("[TB] FAIL fill_3fe got=%h want=5a5a", mem[10'h3FE]); end
    n_cmp++; if (mem[10'h3FF] !== 16'h5A5A) begin n_bad++; $display("[TB] FAIL fill_3ff got=%h want=5a5a", mem[10'h3FF]); end
    n_cmp++; if (mem[10'h000] !== 16'h5A5A) begin n_bad++; $display("[TB] FAIL fill_000 got=%h want=5a5a", mem[10'h000]); end
    n_cmp++; if (mem[10'h001] !== 16'h5A5A) begin n_bad++; $display("[TB] FAIL fill_001 got=%h want=5a5a", mem[10'h001]); end
    n_cmp++; if (mem[10'h002] !== 16'h1111) begin n_bad++; $display("[TB] FAIL fill_002_kept got=%h want=1111", mem[10'h002]); end
    n_cmp++; if (mem[10'h3FD] !== 16'h1111) begin n_bad++; $display("[TB] FAIL fill_3fd_kept got=%h want=1111", mem[10'h3FD]); end
`ifdef MEM_DMA_CHECKSUM_EN
    n_cmp++; if (checksum !== 16'h6968) begin n_bad++; $display("[TB] FAIL fill_checksum got=%h want=6968", checksum); end
`endif
    step();
  endtask

  task automatic test_len_zero();
    int wr0;
    int busy_seen;
    int wr_seen;
    wr0 = wr_count;
    busy_seen = 0;
    wr_seen = 0;
    start_xfer(1'b0, 10'h010, 10'h300, 11'd0, 16'h0000);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("[TB] FAIL len0_done got=%b want=1", done); end
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_seen++;
      if (wr_en) wr_seen++;
      step();
    end
    n_cmp++; if (busy_seen != 0) begin n_bad++; $display("[TB] FAIL len0_busy got=%0d want=0", busy_seen); end
    n_cmp++; if (wr_seen != 0 || wr_count != wr0) begin n_bad++; $display("[TB] FAIL len0_writes got=%0d want=0", wr_count - wr0); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("[TB] FAIL len0_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_start_busy();
    int cyc, bcyc, wcyc, wr0;
    bit to;
    for (int i = 0; i < 5; i++) begin
      mem[10'h100 + i] = 16'h0000;
      mem[10'h300 + i] = 16'h0000;
    end
    wr0 = wr_count;
    start_xfer(1'b1, 10'h000, 10'h100, 11'd4, 16'h7777);
    mode = 1'b1; dst = 10'h300; len = 11'd2; fill_data = 16'h9999;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_done(20, cyc, bcyc, wcyc, to);
    n_cmp++; if (to || cyc != 3) begin n_bad++; $display("[TB] FAIL busy_start_done got=%0d want=3 timeout=%0d", cyc, to); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (mem[10'h100 + i] !== 16'h7777) begin
        n_bad++; $display("[TB] FAIL busy_start_word%0d got=%h want=7777", i, mem[10'h100 + i]);
      end
    end
    n_cmp++; if (mem[10'h300] !== 16'h0000 || mem[10'h301] !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL busy_start_other got=%h_%h want=0000_0000", mem[10'h300], mem[10'h301]);
    end
    n_cmp++; if (wr_count - wr0 != 4) begin n_bad++; $display("[TB] FAIL busy_start_writes got=%0d want=4", wr_count - wr0); end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc, wcyc;
    bit to;
    mem[10'h090] = 16'h0000;
    start_xfer(1'b1, 10'h000, 10'h080, 11'd2, 16'h1234);
    wait_done(20, cyc, bcyc, wcyc, to);
    n_cmp++; if (to || cyc != 3) begin n_bad++; $display("[TB] FAIL b2b_first_done got=%0d want=3 timeout=%0d", cyc, to); end
    start_xfer(1'b1, 10'h000, 10'h090, 11'd1, 16'h4321);
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("[TB] FAIL b2b_second_busy got=busy%b_done%b want=busy1_done0", busy, done);
    end
    wait_done(20, cyc, bcyc, wcyc, to);
    n_cmp++; if (to || cyc != 2) begin n_bad++; $display("[TB] FAIL b2b_second_done got=%0d want=2 timeout=%0d", cyc, to); end
    n_cmp++; if (mem[10'h090] !== 16'h4321) begin n_bad++; $display("[TB] FAIL b2b_word got=%h want=4321", mem[10'h090]); end
    n_cmp++; if (mem[10'h081] !== 16'h1234) begin n_bad++; $display("[TB] FAIL b2b_first_word got=%h want=1234", mem[10'h081]); end
    step();
  endtask

  task automatic test_reset_mid_copy();
    int wr0;
    int done_seen;
    int wr_seen;
    for (int i = 0; i < 8; i++) begin
      mem[10'h040 + i] = 16'h0100 + 16'(i);
      mem[10'h240 + i] = 16'h0000;
    end
    wr0 = wr_count;
    done_seen = 0;
    wr_seen = 0;
    start_xfer(1'b0, 10'h040, 10'h240, 11'd8, 16'h0000);
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
      n_bad++; $display("[TB] FAIL midrst_ctrl got=busy%b_done%b_wr%b want=000", busy, done, wr_en);
    end
    n_cmp++; if (mem_addr !== 10'h000 || wr_data !== 16'h0000) begin
      n_bad++; $display("[TB] FAIL midrst_bus got=%h_%h want=000_0000", mem_addr, wr_data);
    end
    for (int i = 0; i < 10; i++) begin
      if (done) done_seen++;
      if (wr_en) wr_seen++;
      step();
    end
    n_cmp++; if (done_seen != 0 || wr_seen != 0) begin
      n_bad++; $display("[TB] FAIL midrst_after got=done%0d_wr%0d want=0_0", done_seen, wr_seen);
    end
    n_cmp++; if (wr_count - wr0 != 3) begin n_bad++; $display("[TB] FAIL midrst_writes got=%0d want=3", wr_count - wr0); end
    n_cmp++; if (mem[10'h242] !== 16'h0102) begin n_bad++; $display("[TB] FAIL midrst_word2 got=%h want=0102", mem[10'h242]); end
    n_cmp++; if (mem[10'h243] !== 16'h0000) begin n_bad++; $display("[TB] FAIL midrst_word3 got=%h want=0000", mem[10'h243]); end
  endtask

`ifdef MEM_DMA_CHECKSUM_EN
  task automatic test_checksum();
    int cyc, bcyc, wcyc;
    bit to;
    start_xfer(1'b1, 10'h000, 10'h180, 11'd3, 16'hFFFF);
    wait_done(20, cyc, bcyc, wcyc, to);
    n_cmp++; if (to || checksum !== 16'hFFFD) begin
      n_bad++; $display("[TB] FAIL checksum_fill got=%h want=fffd timeout=%0d", checksum, to);
    end
    step();
    n_cmp++; if (checksum !== 16'hFFFD) begin n_bad++; $display("[TB] FAIL checksum_hold got=%h want=fffd", checksum); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    src = '0; dst = '0; len = '0; fill_data = '0;
    for (int i = 0; i < (1 << A); i++) mem[i] = 16'h0000;
    #1;
    test_reset();
    test_copy();
    test_fill_wrap();
    test_len_zero();
    test_start_busy();
    test_back_to_back();
    test_reset_mid_copy();
`ifdef MEM_DMA_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
